// File: rtl/ctrl_pipe_chain.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pipe_chain
//  Description : Carries decoded control bundles from decode through NSTAGE
//                pipeline stages (stage 0 = E, 1 = M, 2 = W, ...). Each stage
//                has its own valid bit, stall and flush. A bubble is inserted
//                behind any held stage. A small FSM keeps a multi-cycle op
//                (mult/div) in stage 0 for MC_LAT cycles.
//                Optional performance counters are enabled by defining the
//                macro CTRL_PIPE_PERF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_pipe_chain #(
    parameter int CTRL_W = 10,
    parameter int NSTAGE = 3,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CTRL_W-1:0]        ctrl_d,
    input  logic                     valid_d,
    input  logic                     mc_d,
    input  logic [NSTAGE-1:0]        stall,
    input  logic [NSTAGE-1:0]        flush,
    output logic [NSTAGE*CTRL_W-1:0] ctrl_q,
    output logic [NSTAGE-1:0]        valid_q,
    output logic                     stall_d,
    output logic                     mc_busy,
    output logic                     mc_done
`ifdef CTRL_PIPE_PERF_EN
    ,
    output logic [31:0]              perf_stall_cnt,
    output logic [31:0]              perf_bubble_cnt
`endif
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------------
    if (NSTAGE < 2) begin : g_badNstage
        $error("ctrl_pipe_chain: NSTAGE must be at least 2");
    end
    if (MC_LAT < 1) begin : g_badMcLat
        $error("ctrl_pipe_chain: MC_LAT must be at least 1");
    end
    if ((2 ** CNT_W) <= MC_LAT) begin : g_badCntW
        $error("ctrl_pipe_chain: CNT_W too narrow for MC_LAT");
    end

    // ------------------------------------------------------------------------
    // Internal signals
    // ------------------------------------------------------------------------
    logic [NSTAGE-1:0]             w_hold;      // stage k must keep its contents
    logic [NSTAGE-1:0]             w_bubble;    // stage k receives an empty slot
    logic                          w_load0;     // stage 0 accepts from decode
    logic [NSTAGE-1:0][CTRL_W-1:0] w_stageCtrl; // per-stage bundle, gathered
    logic [NSTAGE-1:0]             w_stageValid;
    logic                          w_mcBusy;

    // Hold is the OR of the own stall and every downstream stall, so a stall
    // anywhere freezes everything upstream of it; a busy multi-cycle op also
    // pins stage 0.
    always_comb begin
        w_hold = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            w_hold[k] = (|(stall >> k)) | ((k == 0) & w_mcBusy);
        end
    end

    assign w_load0 = ~flush[0] & ~w_hold[0];
    assign stall_d = w_hold[0];
    assign mc_busy = w_mcBusy;

    // ------------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        logic [CTRL_W-1:0] r_ctrl;
        logic              r_valid;

        if (k == 0) begin : g_head
            assign w_bubble[k] = 1'b0;

            // Stage 0: flush clears, hold keeps, otherwise take decode bundle
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ctrl  <= '0;
                    r_valid <= 1'b0;
                end else if (flush[k]) begin
                    r_ctrl  <= '0;
                    r_valid <= 1'b0;
                end else if (w_load0) begin
                    r_ctrl  <= ctrl_d;
                    r_valid <= valid_d;
                end
            end
        end else begin : g_body
            // Upstream is frozen but this stage is free to advance: empty slot
            assign w_bubble[k] = ~flush[k] & ~w_hold[k] & w_hold[k-1];

            // Stage k>0: flush clears, hold keeps, bubble clears, else advance
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ctrl  <= '0;
                    r_valid <= 1'b0;
                end else if (flush[k]) begin
                    r_ctrl  <= '0;
                    r_valid <= 1'b0;
                end else if (w_hold[k]) begin
                    r_ctrl  <= r_ctrl;
                    r_valid <= r_valid;
                end else if (w_bubble[k]) begin
                    r_ctrl  <= '0;
                    r_valid <= 1'b0;
                end else begin
                    r_ctrl  <= w_stageCtrl[k-1];
                    r_valid <= w_stageValid[k-1];
                end
            end
        end

        assign w_stageCtrl[k]                = r_ctrl;
        assign w_stageValid[k]               = r_valid;
        assign ctrl_q[k*CTRL_W +: CTRL_W]    = r_ctrl;
        assign valid_q[k]                    = r_valid;
    end

    // ------------------------------------------------------------------------
    // Multi-cycle op FSM
    // ------------------------------------------------------------------------
    if (MC_LAT > 1) begin : g_mcFsm
        typedef enum logic [0:0] {
            ST_IDLE = 1'b0,
            ST_RUN  = 1'b1
        } mcState_t;

        // Entering RUN already consumes one cycle of the op (the load cycle),
        // and count==0 marks the final busy cycle, hence MC_LAT-2.
        localparam logic [CNT_W-1:0] c_cntInit = CNT_W'(MC_LAT - 2);

        mcState_t         r_state;
        logic [CNT_W-1:0] r_count;

        // Start on a multi-cycle load into stage 0, count down while running;
        // flush of stage 0 aborts the op. Counting ignores downstream stalls.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= ST_IDLE;
                r_count <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_load0 & valid_d & mc_d) begin
                            r_state <= ST_RUN;
                            r_count <= c_cntInit;
                        end
                    end
                    ST_RUN: begin
                        if (flush[0]) begin
                            r_state <= ST_IDLE;
                            r_count <= '0;
                        end else if (r_count == '0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_count <= r_count - 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_count <= '0;
                    end
                endcase
            end
        end

        assign w_mcBusy = (r_state == ST_RUN);
        assign mc_done  = (r_state == ST_RUN) & (r_count == '0);
    end else begin : g_noMc
        assign w_mcBusy = 1'b0;
        assign mc_done  = 1'b0;
    end

`ifdef CTRL_PIPE_PERF_EN
    // ------------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------------
    // Cycles spent holding decode, and cycles where any bubble is inserted
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (w_hold[0]) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (|w_bubble) begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe_chain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_pipe_chain
//  Description : Self-checking bench for ctrl_pipe_chain with a cycle-level
//                behavioural model (arrays plus a remaining-busy-cycles
//                counter), directed scenarios and a randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe_chain;

    localparam int CTRL_W = 10;
    localparam int NSTAGE = 3;
    localparam int MC_LAT = 4;
    localparam int CNT_W  = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [CTRL_W-1:0]        ctrl_d;
    logic                     valid_d;
    logic                     mc_d;
    logic [NSTAGE-1:0]        stall;
    logic [NSTAGE-1:0]        flush;
    logic [NSTAGE*CTRL_W-1:0] ctrl_q;
    logic [NSTAGE-1:0]        valid_q;
    logic                     stall_d;
    logic                     mc_busy;
    logic                     mc_done;
`ifdef CTRL_PIPE_PERF_EN
    logic [31:0]              perf_stall_cnt;
    logic [31:0]              perf_bubble_cnt;
`endif

    ctrl_pipe_chain #(
        .CTRL_W (CTRL_W),
        .NSTAGE (NSTAGE),
        .MC_LAT (MC_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ctrl_d          (ctrl_d),
        .valid_d         (valid_d),
        .mc_d            (mc_d),
        .stall           (stall),
        .flush           (flush),
        .ctrl_q          (ctrl_q),
        .valid_q         (valid_q),
        .stall_d         (stall_d),
        .mc_busy         (mc_busy),
        .mc_done         (mc_done)
`ifdef CTRL_PIPE_PERF_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total;
    int bad;
    int busyCnt;
    int doneCnt;

    // Reference model: contents per stage and number of busy cycles left
    logic [CTRL_W-1:0] mCtrl  [NSTAGE];
    logic              mValid [NSTAGE];
    int                mcLeft;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < NSTAGE; k++) begin
            mCtrl[k]  = '0;
            mValid[k] = 1'b0;
        end
        mcLeft = 0;
    endtask

    task automatic checkStages();
        for (int k = 0; k < NSTAGE; k++) begin
            check($sformatf("ctrl_s%0d", k), 32'(ctrl_q[k*CTRL_W +: CTRL_W]), 32'(mCtrl[k]));
            check($sformatf("valid_s%0d", k), 32'(valid_q[k]), 32'(mValid[k]));
        end
    endtask

    // One clock: drive inputs, check decode-side outputs, advance model, edge,
    // then check the stage registers.
    task automatic cycle(input logic [CTRL_W-1:0] c, input logic v, input logic m,
                         input logic [NSTAGE-1:0] st, input logic [NSTAGE-1:0] fl);
        logic h [NSTAGE];
        ctrl_d  = c;
        valid_d = v;
        mc_d    = m;
        stall   = st;
        flush   = fl;
        #1;
        for (int k = 0; k < NSTAGE; k++) begin
            h[k] = 1'b0;
            for (int j = k; j < NSTAGE; j++) h[k] = h[k] | st[j];
        end
        h[0] = h[0] | (mcLeft > 0);
        check("stall_d", 32'(stall_d), 32'(h[0]));
        check("mc_busy", 32'(mc_busy), 32'(mcLeft > 0));
        check("mc_done", 32'(mc_done), 32'(mcLeft == 1));
        if (mc_busy) busyCnt++;
        if (mc_done) doneCnt++;
        // downstream first, so stage k-1 is still the old value when copied
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (fl[k]) begin
                mCtrl[k] = '0;
                mValid[k] = 1'b0;
            end else if (h[k]) begin
                mCtrl[k] = mCtrl[k];
            end else if (k == 0) begin
                mCtrl[k] = c;
                mValid[k] = v;
            end else if (h[k-1]) begin
                mCtrl[k] = '0;
                mValid[k] = 1'b0;
            end else begin
                mCtrl[k] = mCtrl[k-1];
                mValid[k] = mValid[k-1];
            end
        end
        if (mcLeft > 0) begin
            mcLeft = fl[0] ? 0 : mcLeft - 1;
        end else if (!fl[0] && !h[0] && v && m && MC_LAT > 1) begin
            mcLeft = MC_LAT - 1;
        end
        @(posedge clk);
        #1;
        checkStages();
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        busyCnt = 0;
        doneCnt = 0;

        // Reset with a busy-looking decode input
        rst     = 1'b1;
        ctrl_d  = 10'h3FF;
        valid_d = 1'b1;
        mc_d    = 1'b0;
        stall   = '0;
        flush   = '0;
        repeat (2) @(posedge clk);
        #1;
        modelReset();
        checkStages();
        check("rst_mc_busy", 32'(mc_busy), 32'd0);
        check("rst_ctrl_q", 32'(ctrl_q), 32'd0);
        rst = 1'b0;

        // Flow: three bundles back to back
        cycle(10'h001, 1'b1, 1'b0, 3'b000, 3'b000);
        cycle(10'h002, 1'b1, 1'b0, 3'b000, 3'b000);
        cycle(10'h003, 1'b1, 1'b0, 3'b000, 3'b000);
        check("flow_s2_first", 32'(ctrl_q[2*CTRL_W +: CTRL_W]), 32'h001);
        cycle(10'h000, 1'b0, 1'b0, 3'b000, 3'b000);
        check("flow_s2_second", 32'(ctrl_q[2*CTRL_W +: CTRL_W]), 32'h002);
        cycle(10'h000, 1'b0, 1'b0, 3'b000, 3'b000);
        check("flow_s2_third", 32'(ctrl_q[2*CTRL_W +: CTRL_W]), 32'h003);
        check("flow_s2_valid", 32'(valid_q[2]), 32'd1);

        // Stall of stage 1: A in stage 0, B in stage 1 held, bubble into stage 2
        cycle(10'h0B0, 1'b1, 1'b0, 3'b000, 3'b000);
        cycle(10'h0A0, 1'b1, 1'b0, 3'b000, 3'b000);
        cycle(10'h0C0, 1'b1, 1'b0, 3'b010, 3'b000);
        check("stall_hold_s0", 32'(ctrl_q[0 +: CTRL_W]), 32'h0A0);
        check("stall_hold_s1", 32'(ctrl_q[CTRL_W +: CTRL_W]), 32'h0B0);
        check("stall_bubble_s2", 32'(valid_q[2]), 32'd0);

        // Flush beats stall in stage 0
        cycle(10'h155, 1'b1, 1'b0, 3'b000, 3'b000);
        cycle(10'h007, 1'b1, 1'b0, 3'b001, 3'b001);
        check("flush_vs_stall_ctrl", 32'(ctrl_q[0 +: CTRL_W]), 32'h000);
        check("flush_vs_stall_valid", 32'(valid_q[0]), 32'd0);
        repeat (3) cycle(10'h000, 1'b0, 1'b0, 3'b000, 3'b000);

        // Multi-cycle op occupies stage 0 for MC_LAT cycles
        busyCnt = 0;
        doneCnt = 0;
        cycle(10'h0AA, 1'b1, 1'b1, 3'b000, 3'b000);
        repeat (3) begin
            cycle(10'h0BB, 1'b1, 1'b0, 3'b000, 3'b000);
            check("mc_s0_held", 32'(ctrl_q[0 +: CTRL_W]), 32'h0AA);
            check("mc_s1_bubble", 32'(valid_q[1]), 32'd0);
        end
        cycle(10'h0BB, 1'b1, 1'b0, 3'b000, 3'b000);
        check("mc_s1_arrive", 32'(ctrl_q[CTRL_W +: CTRL_W]), 32'h0AA);
        check("mc_busy_cycles", 32'(busyCnt), 32'd3);
        check("mc_done_pulses", 32'(doneCnt), 32'd1);
        repeat (3) cycle(10'h000, 1'b0, 1'b0, 3'b000, 3'b000);

        // Flush of stage 0 in the second busy cycle aborts the op
        busyCnt = 0;
        doneCnt = 0;
        cycle(10'h0CC, 1'b1, 1'b1, 3'b000, 3'b000);
        cycle(10'h000, 1'b0, 1'b0, 3'b000, 3'b000);
        cycle(10'h000, 1'b0, 1'b0, 3'b000, 3'b001);
        check("abort_busy", 32'(mc_busy), 32'd0);
        check("abort_valid_s0", 32'(valid_q[0]), 32'd0);
        cycle(10'h000, 1'b0, 1'b0, 3'b000, 3'b000);
        check("abort_no_done", 32'(doneCnt), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [NSTAGE-1:0] st;
            logic [NSTAGE-1:0] fl;
            for (int k = 0; k < NSTAGE; k++) begin
                st[k] = ($urandom_range(0, 5) == 0);
                fl[k] = ($urandom_range(0, 11) == 0);
            end
            cycle(CTRL_W'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0), st, fl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
